de_acelp_param: RTL and testbench

- Parametrised fixed-codebook (ACELP) pulse decoder for the G.729 decoder path.
- Takes a packed pulse-position index and a sign word, and builds the algebraic code vector in scratch memory.
- Generalises the 4-pulse/40-sample G.729 decoder to configurable pulse count, position bits, track step, track offset and jitter bit.
- Adds collision accumulation with saturation and an out-of-range position flag.

---
 rtl/de_acelp_param.sv | 162 ++++++++++++++++
 tb/tb_de_acelp_param.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de_acelp_param.sv
// Parametrised ACELP fixed-codebook pulse decoder: unpacks pulse positions and signs,
// then streams the summed, saturated code vector into scratch memory.
module de_acelp_param #(
  parameter int unsigned L_SUBFR   = 40,
  parameter int unsigned NB_PULSE  = 4,
  parameter int unsigned POS_BITS  = 3,
  parameter int unsigned STEP      = 5,
  parameter int unsigned TRACK_OFS = 1,
  parameter int unsigned JIT_EN    = 1,
  parameter logic [11:0] COD_BASE  = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] index_in,
  input  logic [31:0] sign_in,
  output logic        done,
  output logic [11:0] cod_addr,
  output logic [31:0] cod_data,
  output logic        cod_we,
  output logic        pos_err
);

  typedef enum logic [1:0] {StIdle, StDecode, StWrite, StDone} state_e;

  localparam logic [31:0] PosMask = (32'd1 << POS_BITS) - 32'd1;
  // Modulo keeps the select legal when no jitter bit exists above the fields.
  localparam int unsigned JitBit = (NB_PULSE * POS_BITS) % 32;
  localparam logic signed [19:0] AmpPos = 20'sd8191;
  localparam logic signed [19:0] AmpNeg = -20'sd8192;

  state_e                      state_q, state_d;
  logic                        start_prev_q;
  logic [6:0]                  cnt_q, cnt_d;
  logic [31:0]                 index_q, index_d;
  logic [31:0]                 sign_q, sign_d;
  logic [NB_PULSE-1:0][6:0]    pos_q, pos_d;
  logic [NB_PULSE-1:0]         valid_q, valid_d;
  logic                        done_d, we_d, err_d;
  logic [11:0]                 addr_d;
  logic [31:0]                 data_d;

  logic [31:0]        field, pos_calc;
  logic               is_last, jit;
  logic signed [19:0] acc;
  logic [15:0]        sat16;

  always_comb begin
    field    = (index_q >> (32'(cnt_q) * POS_BITS)) & PosMask;
    is_last  = (32'(cnt_q) == NB_PULSE - 1);
    jit      = (JIT_EN != 0) && is_last && index_q[JitBit];
    pos_calc = field * STEP + 32'(cnt_q) * TRACK_OFS + 32'(jit);
  end

  // Collision sum for the sample currently being written.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NB_PULSE; k++) begin
      if (valid_q[k] && (pos_q[k] == cnt_q)) begin
        acc = acc + (sign_q[k] ? AmpPos : AmpNeg);
      end
    end
    if (acc > 20'sd32767) begin
      sat16 = 16'h7fff;
    end else if (acc < -20'sd32768) begin
      sat16 = 16'h8000;
    end else begin
      sat16 = acc[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    index_d = index_q;
    sign_d  = sign_q;
    pos_d   = pos_q;
    valid_d = valid_q;
    err_d   = pos_err;
    done_d  = 1'b0;
    we_d    = 1'b0;
    addr_d  = cod_addr;
    data_d  = cod_data;
    unique case (state_q)
      StIdle: begin
        if (start && !start_prev_q) begin
          index_d = index_in;
          sign_d  = sign_in;
          pos_d   = '0;
          valid_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = StDecode;
        end
      end
      StDecode: begin
        for (int k = 0; k < NB_PULSE; k++) begin
          if (cnt_q == 7'(k)) begin
            if (pos_calc < L_SUBFR) begin
              valid_d[k] = 1'b1;
              pos_d[k]   = pos_calc[6:0];
            end else begin
              err_d = 1'b1;
            end
          end
        end
        if (is_last) begin
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StWrite: begin
        we_d   = 1'b1;
        addr_d = COD_BASE + 12'(cnt_q);
        data_d = {{16{sat16[15]}}, sat16};
        if (cnt_q == 7'(L_SUBFR - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b0;
      cnt_q        <= '0;
      index_q      <= '0;
      sign_q       <= '0;
      pos_q        <= '0;
      valid_q      <= '0;
      done         <= 1'b0;
      cod_we       <= 1'b0;
      cod_addr     <= '0;
      cod_data     <= '0;
      pos_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start;
      cnt_q        <= cnt_d;
      index_q      <= index_d;
      sign_q       <= sign_d;
      pos_q        <= pos_d;
      valid_q      <= valid_d;
      done         <= done_d;
      cod_we       <= we_d;
      cod_addr     <= addr_d;
      cod_data     <= data_d;
      pos_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_de_acelp_param.sv
// Self-checking bench: three decoder configurations driven with directed and random
// index/sign words, compared against an arithmetic model of the pulse rules.
module tb_de_acelp_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [2:0]       start_v, done_v, we_v, err_v;
  logic [2:0][31:0] idx_v, sgn_v, data_v;
  logic [2:0][11:0] addr_v;

  de_acelp_param u_def (
    .clk(clk), .reset(reset), .start(start_v[0]), .index_in(idx_v[0]), .sign_in(sgn_v[0]),
    .done(done_v[0]), .cod_addr(addr_v[0]), .cod_data(data_v[0]), .cod_we(we_v[0]),
    .pos_err(err_v[0])
  );

  de_acelp_param #(
    .L_SUBFR(40), .NB_PULSE(8), .POS_BITS(3), .STEP(1), .TRACK_OFS(0), .JIT_EN(0)
  ) u_sat (
    .clk(clk), .reset(reset), .start(start_v[1]), .index_in(idx_v[1]), .sign_in(sgn_v[1]),
    .done(done_v[1]), .cod_addr(addr_v[1]), .cod_data(data_v[1]), .cod_we(we_v[1]),
    .pos_err(err_v[1])
  );

  de_acelp_param #(
    .L_SUBFR(32)
  ) u_l32 (
    .clk(clk), .reset(reset), .start(start_v[2]), .index_in(idx_v[2]), .sign_in(sgn_v[2]),
    .done(done_v[2]), .cod_addr(addr_v[2]), .cod_data(data_v[2]), .cod_we(we_v[2]),
    .pos_err(err_v[2])
  );

  int p_l[3]    = '{40, 40, 32};
  int p_nb[3]   = '{4, 8, 4};
  int p_step[3] = '{5, 1, 5};
  int p_ofs[3]  = '{1, 0, 1};
  int p_jit[3]  = '{1, 0, 1};

  logic [31:0] mem[3][64];
  int          wcnt[3];
  int          dcnt[3];
  logic [31:0] exp_val[64];
  bit          exp_err;
  int          passed = 0;
  int          total = 0;

  // Capture every write and done pulse of each instance.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (we_v[i] === 1'b1) begin
        mem[i][addr_v[i][5:0]] = data_v[i];
        wcnt[i]++;
      end
      if (done_v[i] === 1'b1) dcnt[i]++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_cap(input int w);
    for (int n = 0; n < 64; n++) mem[w][n] = 32'hdeadbeef;
    wcnt[w] = 0;
    dcnt[w] = 0;
  endtask

  function automatic void model(input int w, input logic [31:0] idx, input logic [31:0] sgn);
    int sum[64];
    int i, j, p;
    for (int n = 0; n < 64; n++) sum[n] = 0;
    exp_err = 1'b0;
    for (int k = 0; k < p_nb[w]; k++) begin
      i = int'((idx >> (k * 3)) & 32'h7);
      j = (p_jit[w] != 0 && k == p_nb[w] - 1) ? int'(idx[p_nb[w] * 3]) : 0;
      p = i * p_step[w] + k * p_ofs[w] + j;
      if (p >= p_l[w]) exp_err = 1'b1;
      else sum[p] += sgn[k] ? 8191 : -8192;
    end
    for (int n = 0; n < 64; n++) begin
      if (sum[n] > 32767) sum[n] = 32767;
      if (sum[n] < -32768) sum[n] = -32768;
      exp_val[n] = 32'(sum[n]);
    end
  endfunction

  // Starts one decode on instance w and returns cycles from the accepting edge to done.
  task automatic run_decode(input int w, input logic [31:0] idx, input logic [31:0] sgn,
                            output int lat);
    clear_cap(w);
    idx_v[w]   = idx;
    sgn_v[w]   = sgn;
    start_v[w] = 1'b1;
    tick();
    start_v[w] = 1'b0;
    lat = 0;
    while (done_v[w] !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start_v = '0;
    idx_v   = '0;
    sgn_v   = '0;
    tick();
    tick();
    for (int w = 0; w < 3; w++) begin
      total += 5;
      if (done_v[w] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", w, done_v[w]);
      else passed++;
      if (we_v[w] !== 1'b0) $display("FAIL reset_we[%0d]: got %b want 0", w, we_v[w]);
      else passed++;
      if (addr_v[w] !== 12'h0) $display("FAIL reset_addr[%0d]: got %h want 000", w, addr_v[w]);
      else passed++;
      if (data_v[w] !== 32'h0) $display("FAIL reset_data[%0d]: got %h want 0", w, data_v[w]);
      else passed++;
      if (err_v[w] !== 1'b0) $display("FAIL reset_err[%0d]: got %b want 0", w, err_v[w]);
      else passed++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    int          cw[7] = '{0, 0, 0, 1, 1, 2, 2};
    logic [31:0] ci[7] = '{32'h0, 32'h1fff, 32'h0208, 32'h0, 32'h0, 32'h1fff, 32'h0};
    logic [31:0] cs[7] = '{32'h0, 32'hf, 32'h5, 32'hff, 32'h0, 32'hf, 32'h0};
    int lat, w;
    for (int c = 0; c < 7; c++) begin
      w = cw[c];
      model(w, ci[c], cs[c]);
      run_decode(w, ci[c], cs[c], lat);
      tick();
      total += 4;
      if (lat != p_nb[w] + p_l[w] + 1)
        $display("FAIL dir_latency[%0d]: got %0d want %0d", c, lat, p_nb[w] + p_l[w] + 1);
      else passed++;
      if (wcnt[w] != p_l[w]) $display("FAIL dir_writes[%0d]: got %0d want %0d", c, wcnt[w], p_l[w]);
      else passed++;
      if (err_v[w] !== exp_err) $display("FAIL dir_pos_err[%0d]: got %b want %b", c, err_v[w], exp_err);
      else passed++;
      if (done_v[w] !== 1'b0) $display("FAIL dir_done_pulse[%0d]: got %b want 0", c, done_v[w]);
      else passed++;
      for (int n = 0; n < p_l[w]; n++) begin
        total++;
        if (mem[w][n] !== exp_val[n])
          $display("FAIL dir_word[%0d][%0d]: got %h want %h", c, n, mem[w][n], exp_val[n]);
        else passed++;
      end
    end
    total += 5;
    if (mem[0][0] !== 32'h00001fff) $display("FAIL jit_addr0: got %h want 00001fff", mem[0][0]);
    else passed++;
    if (mem[0][6] !== 32'hffffe000) $display("FAIL jit_addr6: got %h want ffffe000", mem[0][6]);
    else passed++;
    if (mem[0][2] !== 32'h00001fff) $display("FAIL jit_addr2: got %h want 00001fff", mem[0][2]);
    else passed++;
    if (mem[1][0] !== 32'hffff8000) $display("FAIL sat_neg: got %h want ffff8000", mem[1][0]);
    else passed++;
    if (err_v[2] !== 1'b0) $display("FAIL err_clear: got %b want 0", err_v[2]);
    else passed++;
  endtask

  task automatic test_random();
    int lat, w;
    logic [31:0] idx, sgn;
    for (int it = 0; it < 24; it++) begin
      w   = it % 3;
      idx = $urandom;
      sgn = $urandom;
      model(w, idx, sgn);
      run_decode(w, idx, sgn, lat);
      tick();
      total += 3;
      if (lat != p_nb[w] + p_l[w] + 1)
        $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, lat, p_nb[w] + p_l[w] + 1);
      else passed++;
      if (wcnt[w] != p_l[w]) $display("FAIL rnd_writes[%0d]: got %0d want %0d", it, wcnt[w], p_l[w]);
      else passed++;
      if (err_v[w] !== exp_err) $display("FAIL rnd_pos_err[%0d]: got %b want %b", it, err_v[w], exp_err);
      else passed++;
      for (int n = 0; n < p_l[w]; n++) begin
        total++;
        if (mem[0 + w][n] !== exp_val[n])
          $display("FAIL rnd_word[%0d][%0d]: got %h want %h", it, n, mem[w][n], exp_val[n]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    clear_cap(0);
    idx_v[0]   = 32'h1234;
    sgn_v[0]   = 32'h3;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    while (wcnt[0] < 10 && guard < 100) begin
      tick();
      guard++;
    end
    reset = 1'b1;
    tick();
    total += 2;
    if (we_v[0] !== 1'b0) $display("FAIL midreset_we: got %b want 0", we_v[0]);
    else passed++;
    if (done_v[0] !== 1'b0) $display("FAIL midreset_done: got %b want 0", done_v[0]);
    else passed++;
    reset = 1'b0;
    for (int c = 0; c < 60; c++) tick();
    total += 3;
    if (wcnt[0] != 10) $display("FAIL midreset_writes: got %0d want 10", wcnt[0]);
    else passed++;
    if (dcnt[0] != 0) $display("FAIL midreset_dones: got %0d want 0", dcnt[0]);
    else passed++;
    if (mem[0][10] !== 32'hdeadbeef) $display("FAIL midreset_untouched: got %h want deadbeef", mem[0][10]);
    else passed++;
  endtask

  task automatic test_start_held();
    clear_cap(0);
    model(0, 32'h0a5c, 32'h9);
    idx_v[0]   = 32'h0a5c;
    sgn_v[0]   = 32'h9;
    start_v[0] = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 120; c++) tick();
    total += 2;
    if (dcnt[0] != 1) $display("FAIL held_dones: got %0d want 1", dcnt[0]);
    else passed++;
    if (wcnt[0] != 40) $display("FAIL held_writes: got %0d want 40", wcnt[0]);
    else passed++;
    for (int n = 0; n < 40; n++) begin
      total++;
      if (mem[0][n] !== exp_val[n])
        $display("FAIL held_word[%0d]: got %h want %h", n, mem[0][n], exp_val[n]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    clear_cap(0);
    model(0, 32'h0f0f, 32'h6);
    idx_v[0]   = 32'h0f0f;
    sgn_v[0]   = 32'h6;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    while (wcnt[0] < 5 && guard < 100) begin
      tick();
      guard++;
    end
    idx_v[0]   = 32'h0;
    sgn_v[0]   = 32'hf;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int c = 0; c < 120; c++) tick();
    total += 2;
    if (dcnt[0] != 1) $display("FAIL ignored_start_dones: got %0d want 1", dcnt[0]);
    else passed++;
    if (wcnt[0] != 40) $display("FAIL ignored_start_writes: got %0d want 40", wcnt[0]);
    else passed++;
    for (int n = 0; n < 40; n++) begin
      total++;
      if (mem[0][n] !== exp_val[n])
        $display("FAIL ignored_start_word[%0d]: got %h want %h", n, mem[0][n], exp_val[n]);
      else passed++;
    end
  endtask

  initial begin
    for (int w = 0; w < 3; w++) clear_cap(w);
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_start_held();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
